// File: rtl/jtframe_scan2x_pkg.sv
// Shared types for the scan doubler controller: FSM states and scan-line mode encodings.
package jtframe_scan2x_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        ARMED   = 2'd2,
        LOCKED  = 2'd3
    } scan_state_t;

    localparam logic [1:0] SL_NONE  = 2'd0;
    localparam logic [1:0] SL_DIM2  = 2'd1;
    localparam logic [1:0] SL_DIM4  = 2'd2;
    localparam logic [1:0] SL_BLANK = 2'd3;

endpackage

// File: rtl/jtframe_scan2x_hmeas.sv
// Horizontal timing measurement: HS polarity detection, line length / HS width
// counters and the line-length tolerance compare against the current reference.
module jtframe_scan2x_hmeas #(
    parameter int CNTW = 10,
    parameter int TOL  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pxl_cen,
    input  logic            hs,
    input  logic [CNTW-1:0] ref_len,
    output logic            hs_norm,
    output logic            line_done,
    output logic [CNTW-1:0] cur_len,
    output logic [CNTW-1:0] cur_w,
    output logic            in_tol
);

    localparam logic [CNTW-1:0] MAXC = '1;

    logic            hs_prev, hsn_prev, hs_pol, hs_seen, line_seen;
    logic [CNTW-1:0] high_cnt, low_cnt, len_cnt, w_cnt;
    logic            hsn, hs_rise, hsn_rise;
    logic [CNTW:0]   diff;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] x);
        return (x == MAXC) ? x : x + CNTW'(1);
    endfunction

    assign hsn      = hs_pol ? hs : ~hs;
    assign hs_rise  = hs & ~hs_prev;
    assign hsn_rise = hsn & ~hsn_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_prev   <= 1'b0;
            hsn_prev  <= 1'b0;
            hs_pol    <= 1'b1;
            hs_seen   <= 1'b0;
            line_seen <= 1'b0;
            high_cnt  <= '0;
            low_cnt   <= '0;
            len_cnt   <= '0;
            w_cnt     <= '0;
            hs_norm   <= 1'b0;
        end else begin
            hs_norm <= hsn;
            if (pxl_cen) begin
                hs_prev  <= hs;
                hsn_prev <= hsn;
                // Polarity decided over a full raw HS period; the first period is partial.
                if (hs_rise) begin
                    hs_seen <= 1'b1;
                    if (hs_seen && (high_cnt < low_cnt))      hs_pol <= 1'b1;
                    else if (hs_seen && (high_cnt > low_cnt)) hs_pol <= 1'b0;
                    high_cnt <= CNTW'(1);
                    low_cnt  <= '0;
                end else if (hs) begin
                    high_cnt <= sat_inc(high_cnt);
                end else begin
                    low_cnt <= sat_inc(low_cnt);
                end
                if (hsn_rise) begin
                    line_seen <= 1'b1;
                    len_cnt   <= CNTW'(1);
                    w_cnt     <= CNTW'(1);
                end else begin
                    len_cnt <= sat_inc(len_cnt);
                    if (hsn) w_cnt <= sat_inc(w_cnt);
                end
            end
        end
    end

    assign line_done = pxl_cen & hsn_rise & line_seen;
    assign cur_len   = len_cnt;
    assign cur_w     = w_cnt;

    always_comb begin
        diff = '0;
        if (cur_len >= ref_len) diff = {1'b0, cur_len} - {1'b0, ref_len};
        else                    diff = {1'b0, ref_len} - {1'b0, cur_len};
    end

    assign in_tol = (len_cnt != MAXC) && (diff <= (CNTW+1)'(TOL));

endmodule

// File: rtl/jtframe_scan2x_ctrl.sv
// Scan doubler sequencer: measures native timing, locks, enables the doubler and
// gates OSD settings to frame boundaries. Optional macro: JTFRAME_SCAN2X_CTRL_VCHK_EN.
//
// state   | meaning
// IDLE    | doubling not requested, bypass
// MEASURE | building a reference line length and counting stable lines
// ARMED   | timing stable, waiting for a VS rising edge to lock
// LOCKED  | doubler running, watching for lost timing
module jtframe_scan2x_ctrl
    import jtframe_scan2x_pkg::*;
#(
    parameter int CNTW       = 10,
    parameter int LOCK_LINES = 4,
    parameter int TOL        = 2,
    parameter int LOST_LINES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pxl_cen,
    input  logic            HS,
    input  logic            VS,
    input  logic            req_en,
    input  logic [1:0]      sl_mode_in,
    input  logic            blend_in,
    output logic            scan_en,
    output logic [1:0]      sl_mode,
    output logic            blend_en,
    output logic            hs_norm,
    output logic [CNTW-1:0] hlen,
    output logic [CNTW-1:0] hswidth,
    output logic            locked
);

    localparam logic [3:0] LOCK_IDX = 4'(LOCK_LINES - 1);
    localparam logic [3:0] LOST_IDX = 4'(LOST_LINES);

    scan_state_t     state, state_n;
    logic [CNTW-1:0] ref_len, ref_len_n, ref_w, ref_w_n, hlen_n, hswidth_n;
    logic [3:0]      stable_cnt, stable_n, bad_cnt, bad_n;
    logic            have_ref, have_ref_n, vs_prev, vs_rise, bad_evt;
    logic            scan_en_n, locked_n, blend_n;
    logic [1:0]      sl_mode_n;
    logic            line_done, in_tol, frame_ok;
    logic [CNTW-1:0] cur_len, cur_w;

    jtframe_scan2x_hmeas #(.CNTW(CNTW), .TOL(TOL)) u_hmeas (
        .clk       (clk),
        .rst       (rst),
        .pxl_cen   (pxl_cen),
        .hs        (HS),
        .ref_len   (ref_len),
        .hs_norm   (hs_norm),
        .line_done (line_done),
        .cur_len   (cur_len),
        .cur_w     (cur_w),
        .in_tol    (in_tol)
    );

    assign vs_rise = pxl_cen & VS & ~vs_prev;

`ifdef JTFRAME_SCAN2X_CTRL_VCHK_EN
    logic [CNTW-1:0] lpf_cnt, last_lpf, lpf_total;
    logic            have_last;

    assign lpf_total = lpf_cnt + CNTW'(line_done);
    assign frame_ok  = have_last && (lpf_total == last_lpf);

    always_ff @(posedge clk) begin
        if (rst) begin
            lpf_cnt   <= '0;
            last_lpf  <= '0;
            have_last <= 1'b0;
        end else if (vs_rise) begin
            last_lpf  <= lpf_total;
            have_last <= 1'b1;
            lpf_cnt   <= '0;
        end else if (line_done) begin
            lpf_cnt <= lpf_total;
        end
    end
`else
    assign frame_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ref_len    <= '0;
            ref_w      <= '0;
            have_ref   <= 1'b0;
            stable_cnt <= '0;
            bad_cnt    <= '0;
            vs_prev    <= 1'b0;
            scan_en    <= 1'b0;
            locked     <= 1'b0;
            hlen       <= '0;
            hswidth    <= '0;
            sl_mode    <= SL_NONE;
            blend_en   <= 1'b0;
        end else begin
            if (pxl_cen) vs_prev <= VS;
            state      <= state_n;
            ref_len    <= ref_len_n;
            ref_w      <= ref_w_n;
            have_ref   <= have_ref_n;
            stable_cnt <= stable_n;
            bad_cnt    <= bad_n;
            scan_en    <= scan_en_n;
            locked     <= locked_n;
            hlen       <= hlen_n;
            hswidth    <= hswidth_n;
            sl_mode    <= sl_mode_n;
            blend_en   <= blend_n;
        end
    end

    always_comb begin
        state_n    = state;
        ref_len_n  = ref_len;
        ref_w_n    = ref_w;
        have_ref_n = have_ref;
        stable_n   = stable_cnt;
        bad_n      = bad_cnt;
        scan_en_n  = scan_en;
        locked_n   = locked;
        hlen_n     = hlen;
        hswidth_n  = hswidth;
        sl_mode_n  = sl_mode;
        blend_n    = blend_en;
        bad_evt    = 1'b0;
        if (!req_en) begin
            state_n    = IDLE;
            scan_en_n  = 1'b0;
            locked_n   = 1'b0;
            sl_mode_n  = SL_NONE;
            blend_n    = 1'b0;
            have_ref_n = 1'b0;
            stable_n   = '0;
            bad_n      = '0;
        end else begin
            // Line result is applied first; the VS action below sees the updated state.
            case (state)
                IDLE: begin
                    state_n    = MEASURE;
                    have_ref_n = 1'b0;
                    stable_n   = '0;
                end
                MEASURE, ARMED: if (line_done) begin
                    if (!have_ref || !in_tol) begin
                        ref_len_n  = cur_len;
                        ref_w_n    = cur_w;
                        have_ref_n = 1'b1;
                        stable_n   = '0;
                        state_n    = MEASURE;
                    end else if (stable_cnt != 4'hF) begin
                        stable_n = stable_cnt + 4'd1;
                    end
                    if (stable_n == LOCK_IDX) state_n = ARMED;
                end
                LOCKED: if (line_done) begin
                    if (in_tol) bad_n = '0;
                    else        bad_evt = 1'b1;
                end
                default: state_n = IDLE;
            endcase
            if (vs_rise && (state_n == ARMED) && frame_ok) begin
                state_n   = LOCKED;
                hlen_n    = ref_len_n - CNTW'(1);
                hswidth_n = ref_w_n;
                locked_n  = 1'b1;
                scan_en_n = 1'b1;
                sl_mode_n = sl_mode_in;
                blend_n   = blend_in;
                bad_n     = '0;
            end else if (vs_rise && (state_n == LOCKED)) begin
                sl_mode_n = sl_mode_in;
                blend_n   = blend_in;
                if (!frame_ok) bad_evt = 1'b1;
            end
            if (bad_evt) begin
                if (bad_n != 4'hF) bad_n = bad_n + 4'd1;
                if (bad_n >= LOST_IDX) begin
                    state_n    = MEASURE;
                    locked_n   = 1'b0;
                    scan_en_n  = 1'b0;
                    sl_mode_n  = SL_NONE;
                    blend_n    = 1'b0;
                    have_ref_n = 1'b0;
                    stable_n   = '0;
                    bad_n      = '0;
                end
            end
        end
    end

endmodule
